// File: rtl/adda_pkg.sv
// Shared ADC/display definitions: capture state encoding,
// trigger edge codes and default frame-buffer geometry.
package adda_pkg;

  localparam int ADC_DW = 10;
  localparam int FB_AW  = 9;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TRIG = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_DONE      = 3'd3
  } cap_state_t;

endpackage

// File: rtl/adc_capture_ctrl_trig_detect.sv
// Level-crossing detector: keeps the previous sample while armed,
// hit is a same-cycle pulse on the crossing sample.
module trig_detect
  import adda_pkg::*;
#(
  parameter int DW = ADC_DW
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          arm,
  input  logic          adc_valid,
  input  logic [DW-1:0] adc_data,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_edge,
  output logic          hit
);

  logic [DW-1:0] prev;
  logic          prev_ok;
  logic          above;
  logic          was_above;

  // prev_ok is dropped whenever disarmed, so every arm starts fresh
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      prev    <= '0;
      prev_ok <= 1'b0;
    end else if (!arm) begin
      prev_ok <= 1'b0;
    end else if (adc_valid) begin
      prev    <= adc_data;
      prev_ok <= 1'b1;
    end
  end

  assign above     = adc_data >= trig_level;
  assign was_above = prev >= trig_level;

  always_comb begin
    hit = 1'b0;
    if (arm && adc_valid && prev_ok) begin
      if (trig_edge == EDGE_FALL) hit = was_above && !above;
      else                        hit = !was_above && above;
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered ADC frame capture sequencer (ADC clock domain).
// Optional auto-trigger timeout: define TRIG_TIMEOUT_EN.
module adc_capture_ctrl
  import adda_pkg::*;
#(
  parameter int DW          = ADC_DW,
  parameter int AW          = FB_AW,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  input  logic          start,
  input  logic          cont,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_edge,
  input  logic          frame_ack,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          frame_ready,
  output logic          trig_auto
);

  localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

  cap_state_t  state, state_n;
  logic [AW:0] cnt;
  logic        arm;
  logic        hit;
  logic        force_trig;
  logic        trig_go;
  logic        cap_wr;

  assign arm  = state == ST_WAIT_TRIG;
  assign busy = state != ST_IDLE;

  trig_detect #(.DW(DW)) u_trig (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .arm        (arm),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .hit        (hit)
  );

`ifdef TRIG_TIMEOUT_EN
  localparam int             TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMO = TW'(TIMEOUT_CYC);
  logic [TW-1:0] tmo_cnt;
  logic          auto_q;

  // saturates so the forced trigger waits for the next valid sample
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)               tmo_cnt <= '0;
    else if (!arm)           tmo_cnt <= '0;
    else if (tmo_cnt != TMO) tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign force_trig = arm && adc_valid && (tmo_cnt == TMO);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)        auto_q <= 1'b0;
    else if (trig_go) auto_q <= !hit;
  end

  assign trig_auto = auto_q;
`else
  assign force_trig = 1'b0;
  assign trig_auto  = 1'b0;
`endif

  always_comb begin
    state_n = state;
    trig_go = 1'b0;
    cap_wr  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_n = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: begin
        if (hit || force_trig) begin
          trig_go = 1'b1;
          cap_wr  = 1'b1;
          state_n = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (adc_valid) begin
          cap_wr = 1'b1;
          if (cnt == LAST) state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        if (frame_ack)
          state_n = (cont || start) ? ST_WAIT_TRIG : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_ready <= 1'b0;
    end else begin
      state       <= state_n;
      wr_en       <= cap_wr;
      frame_ready <= (state == ST_DONE) && !frame_ack;
      if (cap_wr) begin
        wr_addr <= trig_go ? '0 : cnt[AW-1:0];
        wr_data <= adc_data;
        cnt     <= trig_go ? ONE : cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomised and directed bench for adc_capture_ctrl,
// checked every cycle against a frame-level reference model.
module tb_adc_capture_ctrl;

  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int FRAME = 8;
  localparam int TMO   = 50;

  logic          CLK;
  logic          RSTn;
  logic [DW-1:0] adc_data;
  logic          adc_valid;
  logic          start;
  logic          cont;
  logic [DW-1:0] trig_level;
  logic          trig_edge;
  logic          frame_ack;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          frame_ready;
  logic          trig_auto;

  int n_assert = 0;
  int n_fail   = 0;
  int obs_addr[$];
  int obs_data[$];

  adc_capture_ctrl #(
    .DW          (DW),
    .AW          (AW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .start       (start),
    .cont        (cont),
    .trig_level  (trig_level),
    .trig_edge   (trig_edge),
    .frame_ack   (frame_ack),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .frame_ready (frame_ready),
    .trig_auto   (trig_auto)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 armed, 2 filling, 3 frame held
  int          m_ph, m_n, m_tcnt;
  bit          m_have;
  logic [DW-1:0] m_prev;
  bit          e_wr, e_ready, e_auto;
  int          e_addr, e_data;

  int          t_ph, t_n, t_tcnt, t_addr, t_data;
  bit          t_have, t_cross, t_tmo, t_wr, t_auto;
  logic [DW-1:0] t_prev;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_ph <= 0; m_n <= 0; m_tcnt <= 0; m_have <= 0; m_prev <= '0;
      e_wr <= 0; e_ready <= 0; e_auto <= 0; e_addr <= 0; e_data <= 0;
    end else begin
      t_ph = m_ph; t_n = m_n; t_tcnt = m_tcnt; t_have = m_have;
      t_prev = m_prev; t_auto = e_auto; t_addr = e_addr; t_data = e_data;
      t_wr = 0; t_cross = 0; t_tmo = 0;
      e_ready <= (m_ph == 3) && !frame_ack;
      case (m_ph)
        0: if (start) begin t_ph = 1; t_have = 0; t_tcnt = 0; end
        1: begin
`ifdef TRIG_TIMEOUT_EN
          t_tmo = (t_tcnt >= TMO);
`endif
          t_tcnt++;
          if (adc_valid) begin
            if (trig_edge)
              t_cross = t_have && t_prev >= trig_level && adc_data < trig_level;
            else
              t_cross = t_have && t_prev < trig_level && adc_data >= trig_level;
            t_prev = adc_data;
            t_have = 1;
            if (t_cross || t_tmo) begin
              t_wr = 1; t_addr = 0; t_data = int'(adc_data);
              t_n = 1; t_ph = 2; t_auto = !t_cross;
            end
          end
        end
        2: if (adc_valid) begin
          t_wr = 1; t_addr = t_n; t_data = int'(adc_data);
          t_n++;
          if (t_n == FRAME) t_ph = 3;
        end
        default: if (frame_ack) begin
          t_ph = (cont || start) ? 1 : 0;
          t_have = 0; t_tcnt = 0;
        end
      endcase
      m_ph <= t_ph; m_n <= t_n; m_tcnt <= t_tcnt; m_have <= t_have;
      m_prev <= t_prev; e_wr <= t_wr; e_addr <= t_addr;
      e_data <= t_data; e_auto <= t_auto;
    end
  end

  always @(negedge CLK) begin
    chk("wr_en", int'(wr_en), int'(e_wr));
    if (e_wr) begin
      chk("wr_addr", int'(wr_addr), e_addr);
      chk("wr_data", int'(wr_data), e_data);
    end
    chk("busy", int'(busy), int'(m_ph != 0));
    chk("frame_ready", int'(frame_ready), int'(e_ready));
    chk("trig_auto", int'(trig_auto), int'(e_auto));
    if (wr_en) begin
      obs_addr.push_back(int'(wr_addr));
      obs_data.push_back(int'(wr_data));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic ack(input logic c);
    cont = c;
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  // Ramp from base by step every cycle until a frame is ready
  task automatic ramp_until_ready(input int base, input int step);
    for (int k = 0; k < 60 && !frame_ready; k++) begin
      adc_valid = 1'b1;
      adc_data  = DW'(base + step * k);
      tick();
    end
    adc_valid = 1'b0;
  endtask

  int base_n;

  initial begin
    RSTn = 1'b0; adc_data = '0; adc_valid = 1'b0; start = 1'b0;
    cont = 1'b0; trig_level = '0; trig_edge = 1'b0; frame_ack = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RSTn = 1'b1;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_ready", int'(frame_ready), 0);
    chk("rst_trig_auto", int'(trig_auto), 0);

    // Rising trigger
    trig_level = 10'd512; trig_edge = 1'b0;
    pulse_start();
    obs_addr.delete(); obs_data.delete();
    ramp_until_ready(500, 5);
    chk("rise_ready", int'(frame_ready), 1);
    chk("rise_count", obs_data.size(), 8);
    if (obs_data.size() == 8) begin
      chk("rise_addr0", obs_addr[0], 0);
      chk("rise_data0", obs_data[0], 515);
      chk("rise_addr7", obs_addr[7], 7);
      chk("rise_data7", obs_data[7], 550);
    end
    ack(1'b0);
    chk("ack_idle_busy", int'(busy), 0);
    chk("ack_ready_drop", int'(frame_ready), 0);

    // Falling trigger, low idle level first
    trig_edge = 1'b1;
    pulse_start();
    obs_addr.delete(); obs_data.delete();
    for (int k = 0; k < 30; k++) begin
      adc_valid = 1'b1; adc_data = 10'd400; tick();
    end
    chk("fall_low_no_trig", obs_data.size(), 0);
    chk("fall_low_busy", int'(busy), 1);
    ramp_until_ready(530, -5);
    chk("fall_count", obs_data.size(), 8);
    if (obs_data.size() == 8) begin
      chk("fall_data0", obs_data[0], 510);
      chk("fall_data7", obs_data[7], 475);
    end
    ack(1'b0);

    // Sparse valid
    trig_edge = 1'b0;
    pulse_start();
    obs_addr.delete(); obs_data.delete();
    for (int k = 0; k < 300 && !frame_ready; k++) begin
      adc_valid = (k % 3 == 0);
      adc_data  = DW'(500 + 5 * (k / 3));
      tick();
    end
    adc_valid = 1'b0;
    chk("sparse_count", obs_addr.size(), 8);
    foreach (obs_addr[i]) chk("sparse_addr", obs_addr[i], i);
    ack(1'b0);

    // Handshake: long hold, then cont re-arm, then drop to idle
    pulse_start();
    obs_addr.delete(); obs_data.delete();
    ramp_until_ready(500, 5);
    for (int k = 0; k < 100; k++) begin
      adc_valid = 1'b1; adc_data = DW'($urandom_range(0, 1023)); tick();
    end
    adc_valid = 1'b0;
    chk("hold_ready", int'(frame_ready), 1);
    chk("hold_no_writes", obs_data.size(), 8);
    ack(1'b1);
    chk("cont_busy", int'(busy), 1);
    chk("cont_ready_drop", int'(frame_ready), 0);
    ramp_until_ready(500, 5);
    chk("cont_count", obs_data.size(), 16);
    cont = 1'b0; start = 1'b0;
    ack(1'b0);
    chk("drop_idle", int'(busy), 0);

    // Reset mid-frame, then start during capture
    pulse_start();
    for (int k = 0; k < 60; k++) begin
      adc_valid = 1'b1; adc_data = DW'(500 + 5 * k); tick();
      if (wr_en && wr_addr == 3'd3) break;
    end
    #2;
    RSTn = 1'b0;
    #1;
    chk("arst_wr_en", int'(wr_en), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(frame_ready), 0);
    chk("arst_addr", int'(wr_addr), 0);
    chk("arst_data", int'(wr_data), 0);
    tick(); tick();
    RSTn = 1'b1;
    base_n = obs_data.size();
    for (int k = 0; k < 20; k++) begin
      adc_valid = 1'b1; adc_data = DW'(480 + 5 * k); tick();
    end
    chk("post_rst_idle", int'(busy), 0);
    chk("post_rst_nowr", obs_data.size(), base_n);
    pulse_start();
    for (int k = 0; k < 60 && !frame_ready; k++) begin
      adc_valid = 1'b1; adc_data = DW'(500 + 5 * k);
      start = (obs_data.size() >= base_n + 2);
      tick();
    end
    start = 1'b0; adc_valid = 1'b0;
    chk("restart_count", obs_data.size(), base_n + 8);
    ack(1'b0);

    // Flat input below level: timeout behaviour
    pulse_start();
    obs_addr.delete(); obs_data.delete();
`ifdef TRIG_TIMEOUT_EN
    for (int k = 0; k < 200 && obs_data.size() == 0; k++) begin
      adc_valid = 1'b1; adc_data = 10'd100; tick();
    end
    chk("tmo_started", int'(obs_data.size() > 0), 1);
    chk("tmo_auto", int'(trig_auto), 1);
    ramp_until_ready(100, 0);
    ack(1'b0);
`else
    for (int k = 0; k < 10000; k++) begin
      adc_valid = 1'b1; adc_data = 10'd100; tick();
    end
    chk("notmo_nowr", obs_data.size(), 0);
    chk("notmo_busy", int'(busy), 1);
    chk("notmo_auto", int'(trig_auto), 0);
    adc_valid = 1'b0;
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
`endif

    // Randomised traffic
    for (int blk = 0; blk < 20; blk++) begin
      trig_level = DW'($urandom_range(200, 800));
      trig_edge  = 1'($urandom_range(0, 1));
      cont       = 1'($urandom_range(0, 1));
      for (int k = 0; k < 200; k++) begin
        adc_valid = ($urandom_range(0, 9) < 6);
        adc_data  = DW'($urandom_range(0, 1023));
        start     = ($urandom_range(0, 15) == 0);
        frame_ack = ($urandom_range(0, 7) == 0);
        tick();
      end
    end
    adc_valid = 1'b0; start = 1'b0; frame_ack = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
